rx_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receive path (valid/ready/data) and extracts framed packets:
//  SOF, LEN, LEN payload bytes, CHK. Each frame is buffered internally and released downstream only

---
 rtl/rx_frame_parser.sv | 174 +++++++++++++++++
 tb/tb_rx_frame_parser.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_parser.sv
// Frame extractor for the UART receive stream: SOF, LEN, payload, CHK.
// Payload is buffered and released downstream only after the checksum verifies.
module rx_frame_parser #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 260417
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [7:0]            frame_len
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [7:0]          len, len_n;
    logic [7:0]          chk, chk_n;
    logic [7:0]          idx, idx_n;
    logic [7:0]          rd_idx, rd_idx_n;
    logic [TCNT_W-1:0]   tcnt, tcnt_n;
    logic                ok_n, err_n;
    logic [1:0]          err_code_n;
    logic [7:0]          frame_len_n;
    logic                in_ready_n, out_valid_n, out_last_n;
    logic                wr_en;
    logic                accept;
    logic [DATA_WIDTH-1:0] mem [MAX_LEN];

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_n     = state;
        len_n       = len;
        chk_n       = chk;
        idx_n       = idx;
        rd_idx_n    = rd_idx;
        tcnt_n      = tcnt;
        ok_n        = 1'b0;
        err_n       = 1'b0;
        err_code_n  = err_code;
        frame_len_n = frame_len;
        wr_en       = 1'b0;
        accept      = in_valid && in_ready;

        // Inter-byte timeout; an accepted byte in the expiry cycle wins
        if (state == LEN || state == PAYLOAD || state == CHECK) begin
            if (accept) begin
                tcnt_n = '0;
            end else if (tcnt == TCNT_LAST) begin
                err_n      = 1'b1;
                err_code_n = 2'b11;
                state_n    = IDLE;
            end else begin
                tcnt_n = tcnt + TCNT_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (accept && in_data == SOF_BYTE) begin
                    state_n = LEN;
                    tcnt_n  = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    if (in_data == '0 || in_data > MAX_LEN_B) begin
                        err_n      = 1'b1;
                        err_code_n = 2'b01;
                        state_n    = IDLE;
                    end else begin
                        len_n   = in_data;
                        chk_n   = in_data;
                        idx_n   = '0;
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    chk_n = chk ^ in_data;
                    idx_n = idx + 8'd1;
                    if (idx == len - 8'd1) state_n = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (in_data == chk) begin
                        ok_n        = 1'b1;
                        frame_len_n = len;
                        rd_idx_n    = '0;
                        state_n     = DRAIN;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = 2'b10;
                        state_n    = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    if (out_last) state_n = IDLE;
                    else          rd_idx_n = rd_idx + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n  = (state_n != DRAIN);
        out_valid_n = (state_n == DRAIN);
        out_last_n  = out_valid_n && (rd_idx_n == len_n - 8'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            chk       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            tcnt      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            frame_len <= '0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            chk       <= chk_n;
            idx       <= idx_n;
            rd_idx    <= rd_idx_n;
            tcnt      <= tcnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;
            err_code  <= err_code_n;
            frame_len <= frame_len_n;
        end
    end

    // Payload buffer; read index only moves on a handshake, so out_data holds while stalled
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx[IDX_W-1:0]] <= in_data;
        out_data <= mem[rd_idx_n[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: stimulus pushes expected bytes/pulses, a monitor pops and compares.
module tb_rx_frame_parser;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [7:0] len;
        int         at_cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, frame_ok, frame_err;
    logic [7:0] out_data, frame_len;
    logic [1:0] err_code;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  bp_mode = 1'b0;

    logic [8:0] exp_q [$];
    ev_t        ev_q [$];

    rx_frame_parser #(
        .DATA_WIDTH(8), .SOF_BYTE(8'hA5), .MAX_LEN(64), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .frame_len(frame_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready, changed just after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e_byte;
    ev_t        e_ev;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid) chk("in_ready_in_drain", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", out_data);
                end else begin
                    e_byte = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e_byte[7:0]));
                    chk("out_last", 32'(out_last), 32'(e_byte[8]));
                end
            end
            if (frame_ok && frame_err) begin
                checks++; errors++;
                $display("FAIL pulse_overlap: got ok=1 err=1 expected at most one");
            end
            if (frame_ok || frame_err) begin
                if (ev_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: got ok=%0b err=%0b expected none", frame_ok, frame_err);
                end else begin
                    e_ev = ev_q.pop_front();
                    chk("pulse_kind_err", 32'(frame_err), 32'(e_ev.is_err));
                    if (e_ev.is_err) chk("err_code", 32'(err_code), 32'(e_ev.code));
                    else             chk("frame_len", 32'(frame_len), 32'(e_ev.len));
                    if (e_ev.at_cyc >= 0) chk("timeout_cycle", 32'(cyc), 32'(e_ev.at_cyc));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_wait: got in_ready=0 expected 1 within 2000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input byte_q_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic expect_frame(input byte_q_t pl);
        ev_t ev;
        foreach (pl[i]) exp_q.push_back({(i == pl.size() - 1) ? 1'b1 : 1'b0, pl[i]});
        ev.is_err = 1'b0; ev.code = 2'b00; ev.len = 8'(pl.size()); ev.at_cyc = -1;
        ev_q.push_back(ev);
    endtask

    task automatic expect_err(input logic [1:0] code, input int at_cyc);
        ev_t ev;
        ev.is_err = 1'b1; ev.code = code; ev.len = 8'h00; ev.at_cyc = at_cyc;
        ev_q.push_back(ev);
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || ev_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d bytes %0d pulses pending expected 0",
                     exp_q.size(), ev_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    byte_q_t pl, fr, good_pl, good_fr;
    logic [7:0] c;
    int n0;

    initial begin
        good_pl = '{8'h11, 8'h22, 8'h33};
        good_fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        rst = 1'b0;

        // Good 3-byte frame
        expect_frame(good_pl);
        send_seq(good_fr);
        in_valid = 1'b0;
        wait_empty();

        // Bad checksum, then a good frame
        expect_err(2'b10, -1);
        fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send_seq(fr);
        expect_frame(good_pl);
        send_seq(good_fr);
        in_valid = 1'b0;
        wait_empty();
        chk("err_code_held", 32'(err_code), 32'd2);

        // Bad LEN values, then a 1-byte frame (CHK = 01^7E = 7F)
        expect_err(2'b01, -1);
        fr = '{8'hA5, 8'h00};
        send_seq(fr);
        expect_err(2'b01, -1);
        fr = '{8'hA5, 8'h41};
        send_seq(fr);
        pl = '{8'h7E};
        expect_frame(pl);
        fr = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(fr);
        in_valid = 1'b0;
        wait_empty();

        // Garbage before SOF; SOF values inside payload are data
        fr = '{8'h00, 8'hFF, 8'h5A};
        send_seq(fr);
        expect_frame(good_pl);
        send_seq(good_fr);
        pl = '{8'hA5, 8'hA5};
        expect_frame(pl);
        fr = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
        send_seq(fr);
        in_valid = 1'b0;
        wait_empty();

        // Max-length frame under random backpressure, next frame queued upstream
        pl = {};
        c = 8'h40;
        for (int i = 0; i < 64; i++) begin
            pl.push_back(8'(i * 7 + 3));
            c = c ^ 8'(i * 7 + 3);
        end
        fr = {};
        fr.push_back(8'hA5);
        fr.push_back(8'h40);
        foreach (pl[i]) fr.push_back(pl[i]);
        fr.push_back(c);
        expect_frame(pl);
        expect_frame(good_pl);
        bp_mode = 1'b1;
        send_seq(fr);
        send_seq(good_fr);
        in_valid = 1'b0;
        wait_empty();
        bp_mode = 1'b0;

        // Timeout: error exactly 100 cycles after the last accepted byte
        fr = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_seq(fr);
        in_valid = 1'b0;
        n0 = cyc;
        expect_err(2'b11, n0 + 100);
        repeat (110) @(negedge clk);
        wait_empty();
        chk("err_code_timeout_held", 32'(err_code), 32'd3);

        // Reset mid-payload discards the frame silently
        send_seq(fr);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_err_code", 32'(err_code), 32'd0);
        chk("midrst_frame_len", 32'(frame_len), 32'd0);
        rst = 1'b0;
        pl = '{8'h7E};
        expect_frame(pl);
        fr = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_seq(fr);
        in_valid = 1'b0;
        wait_empty();
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
